decoder_nx2n_seq: RTL and testbench
===================================

Name: decoder_nx2n_seq

Overview:
- Parametrised, registered successor to the 3-to-8 behavioural decoder: decodes a SEL_W-bit index onto OUT_W output lines.
- Adds thermometer decode, a self-timed scan mode for chip-select or digit strobing, a hold mode and an out-of-range flag.
- Sits between control logic and multiplexed peripherals: 7-segment digit enables, LED banks, chip selects.
- All outputs are registered.

Parameters:
- SEL_W, 3, width of the select index.
- OUT_W, 8, number of output lines. Legal range is 2 to 2**SEL_W.
- SCAN_DIV, 4, clock cycles per scan step. Legal minimum is 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global enable.
- mode  in  2  operating mode: 00 one-hot, 01 thermometer, 10 scan, 11 hold.
- sel  in  SEL_W  select index, used in modes 00 and 01, and as the load value in mode 10.
- load  in  1  mode 10 only: load sel into the scan index.
- y  out  OUT_W  decoded outputs, registered.
- idx  out  SEL_W  current scan index, registered.
- wrap  out  1  one-cycle pulse when the scan index wraps from OUT_W-1 to 0.
- err  out  1  registered flag: sel >= OUT_W was sampled in mode 00 or 01.

Behaviour:
- Reset (async assert, any time, including mid-scan): y=0, idx=0, wrap=0, err=0, internal divider count=0.
- Reset release: the first active edge after deassertion evaluates normally.
- en=0: y<=0, wrap<=0, err<=0; idx and the divider freeze and hold their values.
  - Resuming with en=1 continues the scan from the frozen idx and divider count.
- Latency: one cycle from sampled inputs to y, err, wrap and idx in every mode.
- Mode 00 (one-hot):
  - If sel < OUT_W: y <= 1<<sel.
  - Otherwise: y <= 0 and err <= 1.
  - In-range sel gives err <= 0.
- Mode 01 (thermometer):
  - If sel < OUT_W: y <= bits [sel:0] set, i.e. (2<<sel)-1 truncated to OUT_W.
  - Otherwise: y <= 0 and err <= 1.
- Mode 10 (scan):
  - y <= 1<<idx_next. idx_next is the idx value written on the same edge, so y and idx always agree.
  - err <= 0.
  - The divider counts 0..SCAN_DIV-1. A step occurs on the edge where the divider equals SCAN_DIV-1; the divider then returns to 0.
  - Step rule: idx <= (idx==OUT_W-1) ? 0 : idx+1.
  - wrap <= 1 only on the step edge where idx goes OUT_W-1 -> 0; otherwise wrap <= 0.
  - load=1 has priority over a coincident step:
    - idx <= sel if sel < OUT_W; otherwise idx <= 0.
    - divider <= 0.
    - wrap <= 0.
  - SCAN_DIV=1: idx steps on every enabled edge.
- Mode 11 (hold): y, idx and err keep their values; wrap <= 0; divider frozen.
- Mode change:
  - Takes effect on the next edge, with no glitch cycle.
  - Entering mode 10 from any other mode clears the divider; idx is retained.
  - Leaving mode 10 retains idx.
- load is ignored in modes 00, 01 and 11.
- y is always one-hot or zero, except in thermometer mode; y is never X after reset.
- Width rules:
  - sel is compared against OUT_W at SEL_W+1 bits, so there is no truncation aliasing.
  - Shifts are computed at OUT_W width.

Test Plan:
- Reset and enable: assert rst mid-operation with y=8'h10 → y=0, idx=0, wrap=0, err=0 immediately (async). en=0 with mode=00, sel=3 → y stays 0.
- One-hot sweep: mode=00, en=1, sel=0..7 → y=01,02,04,08,10,20,40,80, one cycle after each sel, err=0. Repeat at OUT_W=6 with sel=6 → y=0, err=1; then sel=2 → y=04, err=0.
- Thermometer: mode=01, sel=0, 3, 7 → y=01, 0F, FF. At OUT_W=6, sel=7 → y=0, err=1.
- Scan with wrap: mode=10, SCAN_DIV=4, from reset → idx advances every 4 cycles 0..7, then 0; y tracks 1<<idx; wrap is high for exactly 1 cycle at the 7→0 step and at no other step.
- Load priority and hold:
  - In scan, assert load with sel=5 on the same edge as a step → idx=5, y=20, divider restarts, so the next step comes 4 cycles later.
  - Switch to mode=11 → y=20 held for 10 cycles, wrap=0.
  - Return to mode=10 → scan resumes from idx=5, reaching idx=6 after 4 cycles.
- Enable freeze: in scan with idx=2 and divider=2, drop en for 5 cycles → y=0, idx stays 2. Raise en → idx=3 two cycles later.

Source files
------------

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N decoder with one-hot, thermometer, scan and hold modes.
// All outputs update one clock after the inputs are sampled.
module decoder_nx2n_seq #(
  parameter int SEL_W    = 3,
  parameter int OUT_W    = 8,
  parameter int SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             wrap,
  output logic             err
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // sel is range-checked one bit wider so OUT_W == 2**SEL_W fits.
  localparam logic [SEL_W:0]   LIM   = (SEL_W+1)'(OUT_W);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(OUT_W - 1);
  localparam logic [DIV_W-1:0] DLAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [OUT_W-1:0] ONE   = OUT_W'(1);
  localparam logic [OUT_W-1:0] TWO   = OUT_W'(2);

  typedef enum logic [1:0] {
    M_ONEHOT = 2'b00,
    M_THERM  = 2'b01,
    M_SCAN   = 2'b10,
    M_HOLD   = 2'b11
  } mode_e;

  logic [DIV_W-1:0] div;
  logic             scan_q;

  logic [OUT_W-1:0] y_d;
  logic [SEL_W-1:0] idx_d;
  logic             wrap_d;
  logic             err_d;
  logic [DIV_W-1:0] div_d;
  logic             scan_d;

  logic             sel_ok;
  logic [DIV_W-1:0] div_cur;
  logic             step;
  logic             at_last;

  // Range check, effective divider and step detection.
  always_comb begin
    sel_ok  = {1'b0, sel} < LIM;
    // A scan entered from another mode starts with a fresh divider.
    div_cur = scan_q ? div : '0;
    step    = (div_cur == DLAST);
    at_last = (idx == LAST);
  end

  // Next-state and output decode for every mode.
  always_comb begin
    y_d    = y;
    idx_d  = idx;
    wrap_d = 1'b0;
    err_d  = err;
    div_d  = div;
    scan_d = scan_q;
    if (!en) begin
      y_d   = '0;
      err_d = 1'b0;
    end else begin
      scan_d = (mode == M_SCAN);
      case (mode)
        M_ONEHOT: begin
          y_d   = sel_ok ? (ONE << sel) : '0;
          err_d = !sel_ok;
        end
        M_THERM: begin
          y_d   = sel_ok ? ((TWO << sel) - ONE) : '0;
          err_d = !sel_ok;
        end
        M_SCAN: begin
          err_d = 1'b0;
          if (load) begin
            idx_d = sel_ok ? sel : '0;
            div_d = '0;
          end else if (step) begin
            idx_d  = at_last ? '0 : idx + SEL_W'(1);
            wrap_d = at_last;
            div_d  = '0;
          end else begin
            div_d = div_cur + DIV_W'(1);
          end
          y_d = ONE << idx_d;
        end
        M_HOLD: begin
          wrap_d = 1'b0;
        end
      endcase
    end
  end

  // Output and scan-state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y      <= '0;
      idx    <= '0;
      wrap   <= 1'b0;
      err    <= 1'b0;
      div    <= '0;
      scan_q <= 1'b0;
    end else begin
      y      <= y_d;
      idx    <= idx_d;
      wrap   <= wrap_d;
      err    <= err_d;
      div    <= div_d;
      scan_q <= scan_d;
    end
  end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Bench for decoder_nx2n_seq: directed checks plus random stimulus
// compared each cycle against a behavioural model (OUT_W=8 and OUT_W=6).
module tb_decoder_nx2n_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] sel = 3'd0;
  logic       load = 1'b0;

  logic [7:0] y8;
  logic [2:0] idx8;
  logic       wrap8, err8;
  logic [5:0] y6;
  logic [2:0] idx6;
  logic       wrap6, err6;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  decoder_nx2n_seq #(.SEL_W(3), .OUT_W(8), .SCAN_DIV(4)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .y(y8), .idx(idx8), .wrap(wrap8), .err(err8)
  );

  decoder_nx2n_seq #(.SEL_W(3), .OUT_W(6), .SCAN_DIV(4)) dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .y(y6), .idx(idx6), .wrap(wrap6), .err(err6)
  );

  // Behavioural model: integer scan position, cycle counter since last step.
  localparam int SD = 4;
  int ow[2] = '{8, 6};
  int m_idx[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  int m_y[2] = '{0, 0};
  int m_w[2] = '{0, 0};
  int m_e[2] = '{0, 0};
  bit m_in_scan = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_idx[i] = 0; m_cnt[i] = 0; m_y[i] = 0; m_w[i] = 0; m_e[i] = 0;
      end
      m_in_scan = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int s;
        s = int'(sel);
        m_w[i] = 0;
        if (!en) begin
          m_y[i] = 0;
          m_e[i] = 0;
        end else if (mode == 2'b00) begin
          m_y[i] = (s < ow[i]) ? (1 << s) : 0;
          m_e[i] = (s < ow[i]) ? 0 : 1;
        end else if (mode == 2'b01) begin
          m_y[i] = (s < ow[i]) ? ((1 << (s + 1)) - 1) : 0;
          m_e[i] = (s < ow[i]) ? 0 : 1;
        end else if (mode == 2'b10) begin
          if (!m_in_scan) m_cnt[i] = 0;
          m_e[i] = 0;
          if (load) begin
            m_idx[i] = (s < ow[i]) ? s : 0;
            m_cnt[i] = 0;
          end else if (m_cnt[i] + 1 >= SD) begin
            m_w[i] = (m_idx[i] + 1 == ow[i]) ? 1 : 0;
            m_idx[i] = (m_idx[i] + 1) % ow[i];
            m_cnt[i] = 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
          m_y[i] = 1 << m_idx[i];
        end
      end
      if (en) m_in_scan = (mode == 2'b10);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("y8", int'(y8), m_y[0]);
      chk("idx8", int'(idx8), m_idx[0]);
      chk("wrap8", int'(wrap8), m_w[0]);
      chk("err8", int'(err8), m_e[0]);
      chk("y6", int'(y6), m_y[1]);
      chk("idx6", int'(idx6), m_idx[1]);
      chk("wrap6", int'(wrap6), m_w[1]);
      chk("err6", int'(err6), m_e[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] oh[8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                        8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] th[3] = '{8'h01, 8'h0F, 8'hFF};
  int         th_sel[3] = '{0, 3, 7};

  initial begin
    int wcnt;
    int wat;
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst_y", int'(y8), 0);
    chk("rst_idx", int'(idx8), 0);
    chk("rst_err", int'(err8), 0);
    rst = 1'b0;

    en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      chk("onehot_y8", int'(y8), int'(oh[i]));
      chk("onehot_err8", int'(err8), 0);
      if (i == 2) chk("onehot_y6_2", int'(y6), 'h04);
      if (i == 6) begin
        chk("onehot_y6_6", int'(y6), 0);
        chk("onehot_err6_6", int'(err6), 1);
      end
    end
    sel = 3'd2;
    tick();
    chk("onehot_err6_clr", int'(err6), 0);

    mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      sel = 3'(th_sel[i]);
      tick();
      chk("therm_y8", int'(y8), int'(th[i]));
    end
    chk("therm_y6_7", int'(y6), 0);
    chk("therm_err6_7", int'(err6), 1);

    en = 1'b0; mode = 2'b00; sel = 3'd3;
    tick();
    chk("en0_y8", int'(y8), 0);

    en = 1'b1; sel = 3'd4;
    tick();
    chk("pre_rst_y8", int'(y8), 'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_y8", int'(y8), 0);
    chk("async_rst_idx8", int'(idx8), 0);
    chk("async_rst_wrap8", int'(wrap8), 0);
    chk("async_rst_err8", int'(err8), 0);
    tick();
    rst = 1'b0; mode = 2'b10;

    wcnt = 0; wat = 0;
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (wrap8) begin
        wcnt++;
        wat = k;
      end
      if (k % 4 == 0) begin
        chk("scan_idx8", int'(idx8), (k / 4) % 8);
        chk("scan_y8", int'(y8), 1 << ((k / 4) % 8));
      end
    end
    chk("scan_wrap_cnt", wcnt, 1);
    chk("scan_wrap_at", wat, 32);

    for (int k = 0; k < 3; k++) tick();
    load = 1'b1; sel = 3'd5;
    tick();
    chk("load_idx8", int'(idx8), 5);
    chk("load_y8", int'(y8), 'h20);
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("load_nostep", int'(idx8), 5);
    end
    tick();
    chk("load_step", int'(idx8), 6);

    load = 1'b1; sel = 3'd5;
    tick();
    load = 1'b0; mode = 2'b11;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_y8", int'(y8), 'h20);
      chk("hold_wrap8", int'(wrap8), 0);
    end
    mode = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("resume_idx8", int'(idx8), 5);
    end
    tick();
    chk("resume_step", int'(idx8), 6);
    chk("resume_y8", int'(y8), 'h40);

    load = 1'b1; sel = 3'd2;
    tick();
    load = 1'b0;
    tick();
    tick();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("freeze_y8", int'(y8), 0);
      chk("freeze_idx8", int'(idx8), 2);
    end
    en = 1'b1;
    tick();
    chk("unfreeze_1", int'(idx8), 2);
    tick();
    chk("unfreeze_2", int'(idx8), 3);

    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      sel = 3'($urandom_range(0, 7));
      load = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    chk_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
